// File: rtl/sram_read_streamer.sv
// sram_read_streamer: streams len consecutive SRAM words from base through a 2-entry FWFT FIFO as valid/ready/last
module sram_read_streamer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [31:0]       len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ren,
  output logic              sram_wen,
  input  logic [WIDTH-1:0]  sram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [31:0] issued_q, issued_d, len_q, len_d, remaining_q, remaining_d;
  logic inflight_q;
  logic [1:0] count_q, count_d;
  logic rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic accept, pop;
  always_comb begin
    busy = state_q == READ || state_q == DRAIN;
    done = state_q == FIN;
    out_valid = count_q != 2'd0;
    out_data = mem_q[rd_ptr_q];
    out_last = out_valid && remaining_q == 32'd1;
    pop = out_valid && out_ready;
    accept = start && !busy;
    sram_wen = 1'b0;
    sram_addr = next_addr_q;
    sram_ren = state_q == READ && issued_q < len_q &&
               {1'b0, count_q} + {2'b0, inflight_q} <= 3'd1 + {2'b0, pop};
    state_d = state_q;
    if (!busy)
      state_d = accept ? (len == 32'd0 ? FIN : READ) : IDLE;
    else if (state_q == READ && sram_ren && issued_q + 32'd1 == len_q)
      state_d = DRAIN;
    else if (state_q == DRAIN && pop && out_last)
      state_d = FIN;
    next_addr_d = accept ? base :
                  sram_ren ? (next_addr_q == ADDR_W'(DEPTH - 1) ? '0 : next_addr_q + ADDR_W'(1)) :
                  next_addr_q;
    issued_d = accept ? 32'd0 : issued_q + 32'(sram_ren);
    len_d = accept ? len : len_q;
    remaining_d = accept ? len : remaining_q - 32'(pop);
    count_d = count_q + 2'(inflight_q) - 2'(pop);
    wr_ptr_d = wr_ptr_q ^ inflight_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    mem_d = mem_q;
    mem_d[wr_ptr_q] = inflight_q ? sram_q : mem_q[wr_ptr_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      next_addr_q <= '0;
      issued_q <= '0;
      len_q <= '0;
      remaining_q <= '0;
      inflight_q <= 1'b0;
      count_q <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      next_addr_q <= next_addr_d;
      issued_q <= issued_d;
      len_q <= len_d;
      remaining_q <= remaining_d;
      inflight_q <= sram_ren;
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_sram_read_streamer.sv
// tb_sram_read_streamer: randomized and directed self-checking bench for sram_read_streamer
module tb_sram_read_streamer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW = $clog2(DEPTH);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] base = '0;
  logic [31:0] len = '0;
  logic busy, done, sram_ren, sram_wen, out_valid, out_last;
  logic [AW-1:0] sram_addr;
  logic [WIDTH-1:0] sram_q, out_data;
  logic [WIDTH-1:0] mem [DEPTH];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sram_read_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .sram_addr(sram_addr), .sram_ren(sram_ren),
    .sram_wen(sram_wen), .sram_q(sram_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );
  always @(posedge clk) sram_q <= sram_ren ? mem[sram_addr] : $urandom;
  int rdy_mode = 0, rdy_k = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  always @(posedge clk) begin
    #1;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[rdy_k % 6] : 1'($urandom_range(0, 1));
    rdy_k++;
  end
  int cyc = 0, outstanding = 0, nren = 0, cur_len = 0, stalls = 0;
  logic [AW-1:0] ren_addr [$];
  int ren_cyc [$];
  logic [WIDTH-1:0] pop_data [$];
  bit pop_last [$];
  int pop_cyc [$];
  int done_cyc [$];
  logic prev_hold = 1'b0, prev_last = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic pop, exp_ren;
    pop = out_valid && out_ready;
    if (!rst) begin
      exp_ren = busy && nren < cur_len && outstanding - int'(pop) < 2;
      checks += 3;
      if (sram_wen !== 1'b0) begin errors++; $display("FAIL wen cyc %0d got %b exp 0", cyc, sram_wen); end
      if (sram_ren !== exp_ren) begin errors++; $display("FAIL ren_rule cyc %0d got %b exp %b", cyc, sram_ren, exp_ren); end
      if (outstanding + int'(sram_ren) - int'(pop) > 2) begin
        errors++; $display("FAIL overflow cyc %0d outstanding %0d exp <=2", cyc, outstanding + int'(sram_ren) - int'(pop));
      end
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          errors++; $display("FAIL stable cyc %0d got v%b %0d l%b exp v1 %0d l%b", cyc, out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (sram_ren) begin ren_addr.push_back(sram_addr); ren_cyc.push_back(cyc); nren++; end
      else if (busy && nren < cur_len) stalls++;
      if (pop) begin pop_data.push_back(out_data); pop_last.push_back(out_last); pop_cyc.push_back(cyc); end
      if (done) done_cyc.push_back(cyc);
      outstanding += int'(sram_ren) - int'(pop);
      if (start && !busy) begin nren = 0; cur_len = int'(len); end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
    end else begin
      outstanding = 0;
      prev_hold = 1'b0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    ren_addr.delete(); ren_cyc.delete(); pop_data.delete(); pop_last.delete();
    pop_cyc.delete(); done_cyc.delete(); stalls = 0;
  endtask
  task automatic preload();
    for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(100 + i);
  endtask
  task automatic start_xfer(input int b, input int l, output int t);
    tick();
    start = 1'b1; base = AW'(b); len = 32'(l); t = cyc;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input int n);
    int k = 0;
    while (done_cyc.size() < n && k < 300) begin tick(); k++; end
    checks++;
    if (done_cyc.size() < n) begin errors++; $display("FAIL done_timeout got %0d pulses exp %0d", done_cyc.size(), n); end
    repeat (2) tick();
  endtask
  task automatic test_reset();
    repeat (3) tick();
    @(negedge clk);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    if (sram_ren !== 1'b0) begin errors++; $display("FAIL rst_ren got %b exp 0", sram_ren); end
    if (sram_addr !== '0) begin errors++; $display("FAIL rst_addr got %0d exp 0", sram_addr); end
    tick();
    rst = 1'b0;
  endtask
  task automatic test_basic();
    int t;
    preload(); clear();
    start_xfer(3, 4, t);
    wait_done(1);
    checks += 3;
    if (ren_addr.size() != 4) begin errors++; $display("FAIL basic_nren got %0d exp 4", ren_addr.size()); end
    if (pop_data.size() != 4) begin errors++; $display("FAIL basic_npop got %0d exp 4", pop_data.size()); end
    if (done_cyc.size() != 1 || done_cyc[0] != t + 7) begin errors++; $display("FAIL basic_done got %0d exp %0d", done_cyc[0], t + 7); end
    foreach (ren_addr[i]) begin
      checks++;
      if (int'(ren_addr[i]) != 3 + i || ren_cyc[i] != t + 1 + i) begin
        errors++; $display("FAIL basic_ren[%0d] got a%0d c%0d exp a%0d c%0d", i, ren_addr[i], ren_cyc[i], 3 + i, t + 1 + i);
      end
    end
    foreach (pop_data[i]) begin
      checks++;
      if (pop_data[i] != WIDTH'(103 + i) || pop_cyc[i] != t + 3 + i || pop_last[i] != (i == 3)) begin
        errors++; $display("FAIL basic_out[%0d] got %0d c%0d l%b exp %0d c%0d l%b", i, pop_data[i], pop_cyc[i], pop_last[i], 103 + i, t + 3 + i, i == 3);
      end
    end
  endtask
  task automatic test_wrap();
    int t;
    int exp_a [4] = '{30, 31, 0, 1};
    preload(); clear();
    start_xfer(30, 4, t);
    wait_done(1);
    checks += 2;
    if (ren_addr.size() != 4) begin errors++; $display("FAIL wrap_nren got %0d exp 4", ren_addr.size()); end
    if (pop_data.size() != 4) begin errors++; $display("FAIL wrap_npop got %0d exp 4", pop_data.size()); end
    for (int i = 0; i < 4 && i < ren_addr.size() && i < pop_data.size(); i++) begin
      checks++;
      if (int'(ren_addr[i]) != exp_a[i] || pop_data[i] != WIDTH'(100 + exp_a[i])) begin
        errors++; $display("FAIL wrap[%0d] got a%0d d%0d exp a%0d d%0d", i, ren_addr[i], pop_data[i], exp_a[i], 100 + exp_a[i]);
      end
    end
  endtask
  task automatic test_backpressure();
    int t;
    preload(); clear();
    rdy_mode = 1; rdy_k = 0;
    start_xfer(0, 6, t);
    wait_done(1);
    rdy_mode = 0;
    checks += 2;
    if (pop_data.size() != 6) begin errors++; $display("FAIL bp_npop got %0d exp 6", pop_data.size()); end
    if (stalls == 0) begin errors++; $display("FAIL bp_stall got %0d stall cycles exp >0", stalls); end
    foreach (pop_data[i]) begin
      checks++;
      if (pop_data[i] != WIDTH'(100 + i) || pop_last[i] != (i == 5)) begin
        errors++; $display("FAIL bp_out[%0d] got %0d l%b exp %0d l%b", i, pop_data[i], pop_last[i], 100 + i, i == 5);
      end
    end
  endtask
  task automatic test_len_zero();
    int t;
    clear();
    start_xfer(5, 0, t);
    repeat (4) tick();
    checks += 3;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 1) begin errors++; $display("FAIL zero_done got n%0d c%0d exp n1 c%0d", done_cyc.size(), done_cyc[0], t + 1); end
    if (ren_addr.size() != 0) begin errors++; $display("FAIL zero_ren got %0d exp 0", ren_addr.size()); end
    if (pop_data.size() != 0) begin errors++; $display("FAIL zero_valid got %0d exp 0", pop_data.size()); end
  endtask
  task automatic test_busy_start();
    int t;
    preload(); clear();
    start_xfer(3, 4, t);
    start = 1'b1; base = AW'(20); len = 32'd9;
    tick();
    start = 1'b0;
    wait_done(1);
    checks += 3;
    if (ren_addr.size() != 4) begin errors++; $display("FAIL busy_nren got %0d exp 4", ren_addr.size()); end
    if (pop_data.size() != 4) begin errors++; $display("FAIL busy_npop got %0d exp 4", pop_data.size()); end
    if (done_cyc.size() != 1 || done_cyc[0] != t + 7) begin errors++; $display("FAIL busy_done got %0d exp %0d", done_cyc[0], t + 7); end
    foreach (pop_data[i]) begin
      checks++;
      if (pop_data[i] != WIDTH'(103 + i)) begin errors++; $display("FAIL busy_out[%0d] got %0d exp %0d", i, pop_data[i], 103 + i); end
    end
  endtask
  task automatic test_reset_mid();
    int t, k;
    preload(); clear();
    start_xfer(0, 8, t);
    k = 0;
    while (pop_data.size() < 3 && k < 50) begin tick(); k++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    if (sram_ren !== 1'b0) begin errors++; $display("FAIL mid_ren got %b exp 0", sram_ren); end
    clear();
    start_xfer(0, 2, t);
    wait_done(1);
    checks++;
    if (pop_data.size() != 2 || pop_data[0] != 100 || pop_data[1] != 101 || pop_last[1] != 1'b1 || pop_last[0] != 1'b0) begin
      errors++; $display("FAIL mid_restart got n%0d %0d %0d exp n2 100 101", pop_data.size(), pop_data[0], pop_data[1]);
    end
  endtask
  task automatic test_back_to_back();
    int t;
    preload(); clear();
    start_xfer(0, 2, t);
    repeat (4) tick();
    start = 1'b1; base = AW'(7); len = 32'd3;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done_cycle got d%b b%b exp d1 b0", done, busy); end
    tick();
    start = 1'b0;
    wait_done(2);
    checks += 3;
    if (ren_addr.size() != 5 || int'(ren_addr[2]) != 7 || ren_cyc[2] != t + 6) begin
      errors++; $display("FAIL b2b_ren got n%0d a%0d c%0d exp n5 a7 c%0d", ren_addr.size(), ren_addr[2], ren_cyc[2], t + 6);
    end
    if (done_cyc.size() != 2 || done_cyc[1] != t + 11) begin errors++; $display("FAIL b2b_done got %0d exp %0d", done_cyc[1], t + 11); end
    if (pop_data.size() != 5 || pop_data[2] != 107 || pop_data[4] != 109 || pop_last[4] != 1'b1) begin
      errors++; $display("FAIL b2b_out got n%0d %0d %0d exp n5 107 109", pop_data.size(), pop_data[2], pop_data[4]);
    end
  endtask
  task automatic test_random();
    int t, b, l;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    rdy_mode = 2;
    for (int n = 0; n < 8; n++) begin
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 12);
      clear();
      start_xfer(b, l, t);
      wait_done(1);
      checks++;
      if (pop_data.size() != l || ren_addr.size() != l) begin
        errors++; $display("FAIL rand%0d_count got p%0d r%0d exp %0d", n, pop_data.size(), ren_addr.size(), l);
      end
      for (int i = 0; i < l && i < pop_data.size() && i < ren_addr.size(); i++) begin
        checks++;
        if (pop_data[i] !== mem[(b + i) % DEPTH] || pop_last[i] != (i == l - 1) || int'(ren_addr[i]) != (b + i) % DEPTH) begin
          errors++; $display("FAIL rand%0d[%0d] got %h a%0d exp %h a%0d", n, i, pop_data[i], ren_addr[i], mem[(b + i) % DEPTH], (b + i) % DEPTH);
        end
      end
    end
    rdy_mode = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_read_streamer.md
# sram_read_streamer

Sequential read engine placed directly downstream of `single_port_sram`. On a `start` pulse it reads `len` consecutive words, beginning at `base` with wrap modulo DEPTH. It presents them as a valid/ready stream with a `last` marker. The engine absorbs the SRAM's fixed one-cycle read latency and non-stallable output in a 2-entry FIFO, so downstream backpressure never loses or duplicates data.

## Interface
- `WIDTH`, 32, data word width; must equal the SRAM's WIDTH.
- `DEPTH`, 32, SRAM depth; ADDR_W = $clog2(DEPTH) (localparam).
- One clock; reset is synchronous and active-high.
- `clk` in 1: single clock; everything samples on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a transfer; accepted only when `busy`=0, ignored otherwise.
- `base` in ADDR_W: first address; sampled on accepted `start`.
- `len` in 32: word count; sampled on accepted `start`; 0 is legal.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at transfer completion.
- `sram_addr` out ADDR_W: read address to the SRAM.
- `sram_ren` out 1: read enable to the SRAM.
- `sram_wen` out 1: tied 0. The SRAM aborts simulation if `ren` and `wen` are both high.
- `sram_q` in WIDTH: SRAM read data.
- `out_valid` out 1: stream data valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out WIDTH: stream data.
- `out_last` out 1: qualifies the final word of the transfer.

## Operation
- States:
  - IDLE -> READ on accepted `start` with `len`>0.
  - IDLE -> DONE on accepted `start` with `len`=0.
  - READ -> DRAIN after the final `sram_ren` issues.
  - DRAIN -> DONE on the handshake of the `out_last` word.
  - DONE -> IDLE unconditionally after one cycle.
- Registers: `next_addr` (ADDR_W), `issued` (32), `remaining_out` (32), `inflight` (1), FIFO `count` (0..2).
- Issue rule:
  - `sram_ren` = (state==READ) & (issued<len) & (count + inflight − pop ≤ 1).
  - pop = `out_valid` & `out_ready`.
  - `sram_ren` is combinational from registered state.
- Address:
  - `sram_addr` = `next_addr`.
  - On issue, `next_addr` <= `next_addr`+1, wrapping from DEPTH−1 to 0 (explicit compare; DEPTH need not be a power of 2).
- Capture:
  - `inflight` <= `sram_ren`.
  - When `inflight`=1, `sram_q` is pushed into the FIFO.
  - `sram_q` is never sampled otherwise; the SRAM drives a dummy value when not reading.
- FIFO:
  - 2 entries, first-word-fall-through.
  - `out_data` = head; `out_valid` = (count>0).
  - Simultaneous push and pop keeps `count` unchanged.
  - Overflow is impossible by the issue rule; the bench asserts it never occurs.
- `out_last` = `out_valid` & (`remaining_out`==1). `remaining_out` decrements on each pop.
- `busy` = (state==READ or DRAIN).
- `done` = (state==DONE).
- Reset values:
  - state IDLE; all counters 0; FIFO empty.
  - `busy`=0, `done`=0, `out_valid`=0, `sram_ren`=0, `sram_addr`=0.
- Reset mid-transfer: returns to IDLE next cycle and discards FIFO contents and in-flight data. A read issued in the reset cycle is not captured.
- `start` in the DONE cycle is accepted, since `busy`=0.

## Timing
- Accepted `start` at cycle t: first `sram_ren` at t+1 with `sram_addr`=`base`.
- Data on `sram_q` at t+2, pushed at the end of t+2; `out_valid` at t+3.
- Start-to-first-valid latency: 3 cycles.
- With `out_ready` held 1: one word per cycle, no bubbles.
  - `len`=N gives words at t+3..t+N+2.
  - `done` at t+N+3.
- With `out_ready`=0: at most 2 reads are outstanding (FIFO + in-flight), then issue stalls. Issue resumes in the same cycle as the first pop.
- `len`=0: `done` at t+1; no `sram_ren`, no `out_valid`.
- `out_data`/`out_last` are stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Preload SRAM[i]=100+i; `base`=3, `len`=4, `out_ready`=1.
  - `sram_ren` at t+1..t+4, addresses 3,4,5,6.
  - Outputs 103,104,105,106 at t+3..t+6; `out_last` only on 106; `done` at t+7.
- Wrap: DEPTH=32, `base`=30, `len`=4.
  - Addresses 30,31,0,1; data 130,131,100,101.
- Backpressure: `base`=0, `len`=6, `out_ready` toggles 1,0,0,1,0,1…
  - Exactly 100..105 delivered in order, no duplicates or drops.
  - Never more than 2 words buffered plus in-flight; `sram_ren` deasserts while the FIFO is full.
- `len`=0 `start`: `done` pulses at t+1; `sram_ren` and `out_valid` stay 0. A `start` during `busy` is ignored: `base`/`len` unchanged, transfer unaffected.
- Reset mid-transfer: `len`=8, assert `rst` after 3 outputs.
  - Next cycle: `busy`=0, `out_valid`=0, `sram_ren`=0.
  - A new `start` with `base`=0, `len`=2 yields 100,101 and `done`.
- Back-to-back: `start` asserted in the DONE cycle of a `len`=2 transfer is accepted; second transfer's first `sram_ren` occurs the next cycle. `sram_wen`=0 throughout all tests.
